// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
// Holds the priority-state encoding and datapath width defaults.
package regfile_wb_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 16;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin grant logic and priority FSM.
// Grants are combinational; the FSM flips to favour the loser.
import regfile_wb_arbiter_pkg::*;

module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_hold,
  output logic o_gnt0,
  output logic o_gnt1
);

  pri_e r_state;
  pri_e w_next;
  logic w_g0;
  logic w_g1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= PRI0;
    else     r_state <= w_next;
  end

  always_comb begin
    w_g0   = 1'b0;
    w_g1   = 1'b0;
    w_next = r_state;
    if (!rst && !i_hold) begin
      unique case (1'b1)
        (i_valid0 && !i_valid1): w_g0 = 1'b1;
        (i_valid1 && !i_valid0): w_g1 = 1'b1;
        (i_valid0 && i_valid1): begin
          w_g0 = (r_state == PRI0);
          w_g1 = (r_state == PRI1);
        end
        default: ;
      endcase
    end
    if (w_g0) w_next = PRI1;
    if (w_g1) w_next = PRI0;
  end

  assign o_gnt0 = w_g0;
  assign o_gnt1 = w_g1;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: merges two write requesters into one
// register-file write port with one-cycle registered latency.
import regfile_wb_arbiter_pkg::*;

module regfile_wb_arbiter #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              hold,
  output logic              regwrite,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic              last_grant,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_acc;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_both;

  logic              r_regwrite;
  logic [ADDR_W-1:0] r_wa;
  logic [DATA_W-1:0] r_wd;
  logic              r_last;
  logic [CNT_W-1:0]  r_cnt;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_hold   (hold),
    .o_gnt0   (w_gnt0),
    .o_gnt1   (w_gnt1)
  );

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign w_acc  = (req0_valid && w_gnt0) || (req1_valid && w_gnt1);
  assign w_addr = w_gnt1 ? req1_addr : req0_addr;
  assign w_data = w_gnt1 ? req1_data : req0_data;
  assign w_both = req0_valid && req1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regwrite <= 1'b0;
      r_wa       <= '0;
      r_wd       <= '0;
      r_last     <= 1'b0;
    end else if (w_acc) begin
      // Register 0 is hard-wired; accept but suppress the write strobe.
      r_regwrite <= (w_addr != '0);
      r_wa       <= w_addr;
      r_wd       <= w_data;
      r_last     <= w_gnt1;
    end else begin
      r_regwrite <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (w_both && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign regwrite     = r_regwrite;
  assign wa           = r_wa;
  assign wd           = r_wd;
  assign last_grant   = r_last;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized + directed bench for regfile_wb_arbiter against a
// behavioural model of the grant rules and write-back pipeline.
module tb_regfile_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          v0 = 1'b0, v1 = 1'b0, hold = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic          rdy0, rdy1, regwrite, last_grant;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [15:0]   conflict_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state
  int          m_fav;
  bit          m_rw;
  int          m_wa;
  longint      m_wd;
  int          m_last;
  int          m_cnt;
  int          e_g;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (v0),
    .req0_addr    (a0),
    .req0_data    (d0),
    .req0_ready   (rdy0),
    .req1_valid   (v1),
    .req1_addr    (a1),
    .req1_data    (d1),
    .req1_ready   (rdy1),
    .hold         (hold),
    .regwrite     (regwrite),
    .wa           (wa),
    .wd           (wd),
    .last_grant   (last_grant),
    .conflict_cnt (conflict_cnt)
  );

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_fav  = 0;
    m_rw   = 0;
    m_wa   = 0;
    m_wd   = 0;
    m_last = 0;
    m_cnt  = 0;
  endtask

  task automatic chk_out();
    chk("regwrite", longint'(regwrite), longint'(m_rw));
    chk("wa", longint'(wa), longint'(m_wa));
    chk("wd", longint'(wd), m_wd);
    chk("last_grant", longint'(last_grant), longint'(m_last));
    chk("conflict_cnt", longint'(conflict_cnt), longint'(m_cnt));
  endtask

  // -1 = no grant, else index of winner
  function automatic int pick(bit r, bit h, bit x0, bit x1, int fav);
    if (r || h) return -1;
    if (x0 && x1) return fav;
    if (x0) return 0;
    if (x1) return 1;
    return -1;
  endfunction

  task automatic cyc(input bit iv0, input int ia0, input longint id0,
                     input bit iv1, input int ia1, input longint id1,
                     input bit ih);
    @(negedge clk);
    v0 = iv0; a0 = AW'(ia0); d0 = DW'(id0);
    v1 = iv1; a1 = AW'(ia1); d1 = DW'(id1);
    hold = ih;
    #1;
    e_g = pick(rst, ih, iv0, iv1, m_fav);
    chk("ready0", longint'(rdy0), longint'(e_g == 0));
    chk("ready1", longint'(rdy1), longint'(e_g == 1));
    @(posedge clk);
    if (iv0 && iv1 && m_cnt < 65535) m_cnt++;
    if (e_g >= 0) begin
      m_fav  = 1 - e_g;
      m_last = e_g;
      m_wa   = (e_g == 0) ? ia0 : ia1;
      m_wd   = (e_g == 0) ? id0 : id1;
      m_rw   = (m_wa != 0);
    end else begin
      m_rw = 0;
    end
    #1;
    chk_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    v0 = 0; v1 = 0; hold = 0;
    #1;
    model_reset();
    chk_out();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    chk_out();
    chk("rst_ready0", longint'(rdy0), 0);
    do_reset();

    // Single requester 0
    cyc(1, 3, 64'hA5A5A5A5, 0, 0, 0, 0);
    chk("d_wa3", longint'(wa), 3);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Sustained contention from reset: 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 4 + i, 64'h100 + i, 1, 12 + i, 64'h200 + i, 0);
      chk("alt_grant", longint'(last_grant), longint'(i % 2));
      chk("alt_rw", longint'(regwrite), 1);
    end
    chk("alt_cnt", longint'(conflict_cnt), 4);

    // Address 0 write is accepted but not strobed
    cyc(0, 0, 0, 1, 0, 64'hFFFFFFFF, 0);
    chk("zero_rw", longint'(regwrite), 0);
    chk("zero_wd", longint'(wd), 64'hFFFFFFFF);

    // Hold blocks grants but contention still counts
    do_reset();
    for (int i = 0; i < 3; i++)
      cyc(1, 7, 64'h77, 1, 9, 64'h99, 1);
    chk("hold_cnt", longint'(conflict_cnt), 3);
    cyc(1, 7, 64'h77, 1, 9, 64'h99, 0);
    chk("hold_first", longint'(last_grant), 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31),
          longint'($urandom),
          $urandom_range(0, 1), $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31),
          longint'($urandom),
          $urandom_range(0, 3) == 0);
    end

    // Counter saturation
    while (m_cnt < 65530)
      cyc(1, 1, 1, 1, 2, 2, 1);
    for (int i = 0; i < 10; i++)
      cyc(1, 1, 1, 1, 2, 2, 1);
    chk("sat_cnt", longint'(conflict_cnt), 64'hFFFF);

    // Reset during an acceptance cycle
    cyc(1, 5, 64'h55, 0, 0, 0, 0);
    @(negedge clk);
    v0 = 1; a0 = 5'd6; d0 = 32'h66;
    #1;
    chk("mid_ready_pre", longint'(rdy0), 1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_ready", longint'(rdy0), 0);
    chk_out();
    @(posedge clk);
    #1;
    chk_out();
    @(negedge clk);
    rst = 1'b0;
    v0 = 0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_rw", longint'(regwrite), 0);
    cyc(1, 8, 64'h88, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
